mem_access_seq: RTL

Memory access sequencer for the multicycle datapath. It arbitrates between instruction fetch, data load/store and exception-vector read requests. It drives the 2-bit address-source select (`IorD`) into the memory address mux and pulses the memory write enable. It also waits out the memory's fixed read latency and returns captured read data with a one-cycle done pulse. It sits between the main control unit and the memory/address-mux pair, and is the control end of the `IorD` select path.

---
 rtl/mem_access_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_seq.sv
// ============================================================================
//  Module      : mem_access_seq
//  Description : Memory access sequencer for the multicycle datapath.
//                Arbitrates fetch / load-store / exception-vector reads
//                (priority exc > data > fetch), drives the IorD address
//                select, pulses mem_wr for stores, waits out MEM_LAT read
//                cycles, captures read data and pulses a per-owner done.
//  Options     : `define MEM_ACCESS_SEQ_PERF_EN builds the 32-bit access
//                counter on acc_count; otherwise acc_count is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_access_seq #(
  parameter int MEM_LAT = 1            // read latency in cycles, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic        data_req,
  input  logic        data_we,
  input  logic        exc_req,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  IorD,
  output logic        mem_wr,
  output logic [31:0] rdata,
  output logic        fetch_done,
  output logic        data_done,
  output logic        exc_done,
  output logic        busy,
  output logic [31:0] acc_count
);

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Owner codes double as the IorD select values
  localparam logic [1:0] OWN_FETCH = 2'b00;
  localparam logic [1:0] OWN_DATA  = 2'b01;
  localparam logic [1:0] OWN_EXC   = 2'b10;

  // Counter preload: WAIT lasts MEM_LAT cycles, ending when the count is 0
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;   // also the registered IorD value
  logic        we_q,    we_d;      // store flag latched at grant
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic [1:0]  winner;
  logic        winner_we;

  // Fixed-priority arbitration among the pending requests
  always_comb begin
    any_req   = exc_req | data_req | fetch_req;
    winner    = OWN_FETCH;
    winner_we = 1'b0;
    if (exc_req) begin
      winner = OWN_EXC;
    end else if (data_req) begin
      winner    = OWN_DATA;
      winner_we = data_we;
    end
  end

  // State register and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= OWN_FETCH;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = we_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Always return to IDLE so a held request is re-arbitrated fresh
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grant latch, latency counter and read-data capture
  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        // IorD only moves on the IDLE->ISSUE edge; otherwise it holds
        if (any_req) begin
          owner_d = winner;
          we_d    = winner_we;
        end
      end
      S_ISSUE: begin
        if (!we_q) begin
          cnt_d = LAT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Outputs decoded from registered state only (no input-to-output paths)
  always_comb begin
    IorD       = owner_q;
    rdata      = rdata_q;
    busy       = (state_q != S_IDLE);
    mem_wr     = 1'b0;
    fetch_done = 1'b0;
    data_done  = 1'b0;
    exc_done   = 1'b0;
    if (state_q == S_ISSUE && owner_q == OWN_DATA && we_q) begin
      mem_wr = 1'b1;
    end
    if (state_q == S_DONE) begin
      fetch_done = (owner_q == OWN_FETCH);
      data_done  = (owner_q == OWN_DATA);
      exc_done   = (owner_q == OWN_EXC);
    end
  end

`ifdef MEM_ACCESS_SEQ_PERF_EN
  logic [31:0] acc_q;

  // Count one completed access per DONE cycle, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= 32'd0;
    end else if (state_q == S_DONE) begin
      acc_q <= acc_q + 32'd1;
    end
  end

  assign acc_count = acc_q;
`else
  assign acc_count = 32'd0;
`endif

endmodule

`default_nettype wire
